// File: rtl/led_pattern_pkg.sv
// Shared types and the mode-sequencing helper for led_pattern_gen.
// Define LED_PATTERN_BREATHE_EN to include the PWM breathe mode in the mode cycle.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      MODE_BLINK:  n = MODE_CHASE;
      MODE_CHASE:  n = MODE_BOUNCE;
`ifdef LED_PATTERN_BREATHE_EN
      MODE_BOUNCE: n = MODE_BREATHE;
`else
      MODE_BOUNCE: n = MODE_BLINK;
`endif
      default:     n = MODE_BLINK;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_q;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_rise     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      r_rise     <= r_stable & ~r_stable_q;
      // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level      = r_stable;
  assign rise_pulse = r_rise;

endmodule

// File: rtl/led_pattern_gen.sv
// Animated LED pattern generator (blink / chase / bounce, plus PWM breathe when
// LED_PATTERN_BREATHE_EN is defined); a debounced button press steps the mode.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int CLK_HZ          = 100_000_000,
  parameter int STEP_HZ         = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PWM_BITS        = 8,
  parameter int RAMP_DIV        = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                press,
  output logic                step_tick
);

  localparam int STEP_DIV = CLK_HZ / STEP_HZ;
  localparam int PW       = $clog2(STEP_DIV);
  localparam int POSW     = $clog2(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] ONE_HOT0 = NUM_LEDS'(1);

  logic [PW-1:0]       r_pre;
  logic                w_tick;
  logic                w_level;
  logic                w_rise;
  logic                w_press;

  mode_e               r_mode,  w_mode_n;
  logic [POSW-1:0]     r_pos,   w_pos_n;
  dir_e                r_dir,   w_dir_n;
  logic                r_phase, w_phase_n;
  logic [NUM_LEDS-1:0] r_led,   w_led_n;

`ifdef LED_PATTERN_BREATHE_EN
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PWM_BITS-1:0] r_pwm,      w_pwm_n;
  logic [RW-1:0]       r_ramp,     w_ramp_n;
  logic [PWM_BITS-1:0] r_duty,     w_duty_n;
  dir_e                r_duty_dir, w_duty_dir_n;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn),
    .level     (w_level),
    .rise_pulse(w_rise)
  );

  // The rise pulse always lands while the debounced level is still high.
  assign w_press = w_rise & w_level;
  assign w_tick  = (r_pre == PW'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_mode_n  = r_mode;
    w_pos_n   = r_pos;
    w_dir_n   = r_dir;
    w_phase_n = r_phase;
`ifdef LED_PATTERN_BREATHE_EN
    w_pwm_n      = r_pwm + 1'b1;
    w_ramp_n     = r_ramp;
    w_duty_n     = r_duty;
    w_duty_dir_n = r_duty_dir;
`endif
    if (w_press) begin
      // A press restarts the pattern and swallows any coincident step tick.
      w_mode_n  = next_mode(r_mode);
      w_pos_n   = '0;
      w_dir_n   = DIR_UP;
      w_phase_n = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
      w_pwm_n      = '0;
      w_ramp_n     = '0;
      w_duty_n     = '0;
      w_duty_dir_n = DIR_UP;
`endif
    end else begin
`ifdef LED_PATTERN_BREATHE_EN
      if (r_pwm == '1) begin
        if (r_ramp == RW'(RAMP_DIV - 1)) begin
          w_ramp_n = '0;
          if (r_duty_dir == DIR_UP) begin
            if (r_duty == '1) begin
              w_duty_dir_n = DIR_DOWN;
              w_duty_n     = r_duty - 1'b1;
            end else begin
              w_duty_n = r_duty + 1'b1;
            end
          end else begin
            if (r_duty == '0) begin
              w_duty_dir_n = DIR_UP;
              w_duty_n     = r_duty + 1'b1;
            end else begin
              w_duty_n = r_duty - 1'b1;
            end
          end
        end else begin
          w_ramp_n = r_ramp + 1'b1;
        end
      end
`endif
      if (w_tick) begin
        case (r_mode)
          MODE_BLINK: w_phase_n = ~r_phase;
          MODE_CHASE: w_pos_n = (r_pos == POSW'(NUM_LEDS - 1)) ? '0 : r_pos + 1'b1;
          MODE_BOUNCE: begin
            if (r_dir == DIR_UP) begin
              if (r_pos == POSW'(NUM_LEDS - 1)) begin
                w_dir_n = DIR_DOWN;
                w_pos_n = r_pos - 1'b1;
              end else begin
                w_pos_n = r_pos + 1'b1;
              end
            end else begin
              if (r_pos == '0) begin
                w_dir_n = DIR_UP;
                w_pos_n = r_pos + 1'b1;
              end else begin
                w_pos_n = r_pos - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // LEDs are derived from the next state so they update on the same edge.
    case (w_mode_n)
      MODE_BLINK:  w_led_n = {NUM_LEDS{w_phase_n}};
      MODE_CHASE:  w_led_n = ONE_HOT0 << w_pos_n;
      MODE_BOUNCE: w_led_n = ONE_HOT0 << w_pos_n;
`ifdef LED_PATTERN_BREATHE_EN
      MODE_BREATHE: w_led_n = {NUM_LEDS{(w_pwm_n < w_duty_n)}};
`endif
      default:     w_led_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE_BLINK;
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      r_phase <= 1'b0;
      r_led   <= '0;
`ifdef LED_PATTERN_BREATHE_EN
      r_pwm      <= '0;
      r_ramp     <= '0;
      r_duty     <= '0;
      r_duty_dir <= DIR_UP;
`endif
    end else begin
      r_mode  <= w_mode_n;
      r_pos   <= w_pos_n;
      r_dir   <= w_dir_n;
      r_phase <= w_phase_n;
      r_led   <= w_led_n;
`ifdef LED_PATTERN_BREATHE_EN
      r_pwm      <= w_pwm_n;
      r_ramp     <= w_ramp_n;
      r_duty     <= w_duty_n;
      r_duty_dir <= w_duty_dir_n;
`endif
    end
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign press     = w_press;
  assign step_tick = w_tick;

endmodule
